acc_block_param: RTL
====================

ACC_BLOCK_PARAM -- requirements
Module: acc_block_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data and sum width in bits, at least 2.
REQ-002 SHALL have parameter BLOCK_LEN, default 4: samples per block, at least 1.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = modulo-2^WIDTH wrap, 1 = clamp at all-ones.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_data  input  WIDTH  unsigned sample.
REQ-008 in_valid  input  1  sample present.
REQ-009 in_ready  output  1  block can accept a sample.
REQ-010 clear  input  1  synchronous abort of the current partial block.
REQ-011 run_sum  output  WIDTH  running accumulator value.
REQ-012 out_data  output  WIDTH  completed block sum.
REQ-013 out_ovf  output  1  overflow occurred in the completed block.
REQ-014 out_valid  output  1  out_data/out_ovf valid.
REQ-015 out_ready  input  1  consumer accepts the result.

Function
REQ-016 SHALL implement a two-state FSM: ACC and HOLD.
REQ-017 In ACC, in_ready SHALL be 1 and out_valid 0; in HOLD, in_ready SHALL be 0 and out_valid 1.
REQ-018 A sample is accepted only on a cycle with in_valid=1 and in_ready=1.
- On acceptance: acc <= acc + in_data; cnt <= cnt + 1.
REQ-019 Addition SHALL be unsigned WIDTH+1 bits; carry-out sets the sticky ovf flag.
- SATURATE=0: acc keeps the low WIDTH bits.
- SATURATE=1: acc <= all-ones on carry; further additions stay at all-ones.
REQ-020 Accepting the sample with cnt = BLOCK_LEN-1 SHALL, on the same edge:
- load out_data with the sum including that sample;
- load out_ovf with the ovf flag including that addition;
- enter HOLD.
- Latency: out_valid rises the cycle after the last sample is accepted.
REQ-021 In HOLD, out_data and out_ovf SHALL stay stable until out_valid and out_ready are both 1.
REQ-022 On the HOLD handshake edge:
- acc, cnt and ovf clear to 0;
- FSM returns to ACC, so out_valid falls the next cycle.
- in_valid is not accepted on that edge.
REQ-023 run_sum SHALL equal acc at all times; in HOLD it shows the final block sum.
REQ-024 clear in ACC SHALL zero acc, cnt and ovf and discard any coincident sample (clear has priority).
REQ-025 clear in HOLD SHALL be ignored; the pending result is never lost.
REQ-026 BLOCK_LEN=1: every accepted sample produces a result, with sum = in_data and ovf = 0.
REQ-027 cnt SHALL be $clog2(BLOCK_LEN)+1 bits wide and never exceed BLOCK_LEN-1.

Reset
REQ-028 reset SHALL set the FSM to ACC and zero acc, cnt, ovf, out_data and out_ovf.
- Resulting outputs: out_valid=0, in_ready=1, run_sum=0.
REQ-029 reset SHALL override clear, handshake and sample acceptance in any state, including mid-block and in HOLD.

Structure
REQ-030 Package acc_pkg SHALL hold the state enum typedef (ACC, HOLD) and the default parameter constants.
REQ-031 One combinational sub-module, acc_add_sat, SHALL implement the add, carry and saturate logic.
- Its parameters are WIDTH and SATURATE.
- It outputs the next sum and the carry.
REQ-032 The FSM, counter and result registers SHALL live in acc_block_param.

Verification (WIDTH=8, BLOCK_LEN=4 unless stated)
REQ-033 SATURATE=0, samples 10,20,30,40 back-to-back -> cycle after 40: out_valid=1, out_data=100, out_ovf=0.
REQ-034 SATURATE=0, samples 200,100,0,0 -> out_data=44, out_ovf=1.
REQ-035 SATURATE=1, samples 200,100,5,5 -> out_data=255, out_ovf=1, run_sum stays 255 after the 2nd sample.
REQ-036 Back-pressure: out_ready=0 for 3 cycles in HOLD while in_valid=1.
- Expected: out_data held, in_ready=0, no sample absorbed.
- Then out_ready=1, samples 1,2,3,4 -> out_data=10.
REQ-037 clear after samples 7,8, then samples 1,2,3,4 -> out_data=10; clear asserted in HOLD -> result unchanged.
REQ-038 reset after 2 samples, and again during HOLD -> next cycle run_sum=0, out_valid=0, in_ready=1, out_data=0.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types and default sizing for the block accumulator.
package acc_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } acc_state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_BLOCK_LEN = 4;
    localparam int DEF_SATURATE  = 0;

endpackage

// File: rtl/acc_add_sat.sv
// Unsigned adder with carry-out and optional clamp to all-ones.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module acc_add_sat import acc_pkg::*; #(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int SATURATE = DEF_SATURATE
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] sum_full;

    always_comb begin
        sum_full = {1'b0, a} + {1'b0, b};
        carry    = sum_full[WIDTH];
        if ((SATURATE != 0) && sum_full[WIDTH]) begin
            sum = '1;
        end else begin
            sum = sum_full[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/acc_block_param.sv
// Sums BLOCK_LEN accepted samples and presents the block sum with a sticky overflow flag.
// Latency: out_valid rises the cycle after the last sample of a block is accepted.
// Backpressure: in_ready is low while a result waits in HOLD; clear is ignored there.
module acc_block_param import acc_pkg::*; #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BLOCK_LEN = DEF_BLOCK_LEN,
    parameter int SATURATE  = DEF_SATURATE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic [WIDTH-1:0] run_sum,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = $clog2(BLOCK_LEN) + 1;

    acc_state_t       state;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             ovf;
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;
    logic             last;

    acc_add_sat #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_add (
        .a     (acc),
        .b     (in_data),
        .sum   (add_sum),
        .carry (add_carry)
    );

    assign last      = (cnt == CW'(BLOCK_LEN - 1));
    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);
    assign run_sum   = acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ACC;
            acc      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (clear) begin
                        acc <= '0;
                        cnt <= '0;
                        ovf <= 1'b0;
                    end else if (in_valid) begin
                        acc <= add_sum;
                        ovf <= ovf | add_carry;
                        // acc keeps the final sum so run_sum shows it during HOLD
                        if (last) begin
                            out_data <= add_sum;
                            out_ovf  <= ovf | add_carry;
                            state    <= HOLD;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                        state <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule
